// File: rtl/ram_ahb2_arbiter.sv
// Two AHB-lite slave ports (m0 instruction, m1 data) sharing one single-port synchronous RAM.
// Each port runs its own small FSM; a round-robin arbiter picks which pending port owns the RAM this cycle.
module ram_ahb2_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  m0_hsel,
  input  logic [31:0]           m0_haddr,
  input  logic [1:0]            m0_htrans,
  input  logic                  m0_hwrite,
  input  logic [2:0]            m0_hsize,
  input  logic [31:0]           m0_hwdata,
  output logic [31:0]           m0_hrdata,
  output logic                  m0_hready,
  output logic                  m0_hresp,
  input  logic                  m1_hsel,
  input  logic [31:0]           m1_haddr,
  input  logic [1:0]            m1_htrans,
  input  logic                  m1_hwrite,
  input  logic [2:0]            m1_hsize,
  input  logic [31:0]           m1_hwdata,
  output logic [31:0]           m1_hrdata,
  output logic                  m1_hready,
  output logic                  m1_hresp,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {IDLE, PEND, ACC, ERR1, ERR2} state_t;

  logic [1:0]            sel_in, trans_ok, wr_in;
  logic [31:0]           addr_in  [2];
  logic [2:0]            size_in  [2];
  logic [31:0]           wdata_in [2];

  state_t                st       [2];
  logic [ADDR_WIDTH+1:0] paddr    [2];
  logic [1:0]            psize    [2];
  logic [31:0]           rdata_q  [2];
  logic [1:0]            pwrite, hready_q, hresp_q;
  logic                  last_grant;

  logic [1:0]            capture, bad, req, gnt;
  logic                  gp;
  logic                  unused_htrans;

  assign sel_in   = {m1_hsel, m0_hsel};
  assign trans_ok = {m1_htrans[1], m0_htrans[1]};
  assign wr_in    = {m1_hwrite, m0_hwrite};
  assign addr_in[0]  = m0_haddr;
  assign addr_in[1]  = m1_haddr;
  assign size_in[0]  = m0_hsize;
  assign size_in[1]  = m1_hsize;
  assign wdata_in[0] = m0_hwdata;
  assign wdata_in[1] = m1_hwdata;
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

  // Own hready doubles as HREADYIN, so a port only takes a new address phase when it is not stalling.
  always_comb begin
    capture = '0;
    bad     = '0;
    for (int p = 0; p < 2; p++) begin
      capture[p] = sel_in[p] & trans_ok[p] & hready_q[p];
      bad[p] = (size_in[p] > 3'd2)
             || (size_in[p] == 3'd1 && addr_in[p][0])
             || (size_in[p] == 3'd2 && addr_in[p][1:0] != 2'b00)
             || (|addr_in[p][31:ADDR_WIDTH+2]);
    end
  end

  assign req    = {st[1] == PEND, st[0] == PEND};
  assign gnt[0] = req[0] & (~req[1] | last_grant);
  assign gnt[1] = req[1] & ~gnt[0];
  assign gp     = gnt[1];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int p = 0; p < 2; p++) begin
        st[p]      <= IDLE;
        paddr[p]   <= '0;
        psize[p]   <= '0;
        rdata_q[p] <= '0;
      end
      pwrite     <= '0;
      hready_q   <= 2'b11;
      hresp_q    <= '0;
      last_grant <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (st[p] == ACC && !pwrite[p]) rdata_q[p] <= ram_rdata;
        if (capture[p]) begin
          paddr[p]    <= addr_in[p][ADDR_WIDTH+1:0];
          psize[p]    <= size_in[p][1:0];
          pwrite[p]   <= wr_in[p];
          hready_q[p] <= 1'b0;
          hresp_q[p]  <= bad[p];
          st[p]       <= bad[p] ? ERR1 : PEND;
        end else begin
          case (st[p])
            PEND: if (gnt[p]) begin
              st[p]       <= ACC;
              hready_q[p] <= 1'b1;
            end
            ERR1: begin
              st[p]       <= ERR2;
              hready_q[p] <= 1'b1;
              hresp_q[p]  <= 1'b1;
            end
            default: begin
              st[p]       <= IDLE;
              hready_q[p] <= 1'b1;
              hresp_q[p]  <= 1'b0;
            end
          endcase
        end
      end
      if (gnt[0])      last_grant <= 1'b0;
      else if (gnt[1]) last_grant <= 1'b1;
    end
  end

  // The granted port drives the RAM in the same cycle; hwdata is stable because hready is still low.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (|gnt) begin
      ram_en    = 1'b1;
      ram_we    = pwrite[gp];
      ram_addr  = paddr[gp][ADDR_WIDTH+1:2];
      ram_wdata = wdata_in[gp];
      ram_be    = 4'b1111;
      if (pwrite[gp]) begin
        case (psize[gp])
          2'd0:    ram_be = 4'b0001 << paddr[gp][1:0];
          2'd1:    ram_be = paddr[gp][1] ? 4'b1100 : 4'b0011;
          default: ram_be = 4'b1111;
        endcase
      end
    end
  end

  assign m0_hready = hready_q[0];
  assign m1_hready = hready_q[1];
  assign m0_hresp  = hresp_q[0];
  assign m1_hresp  = hresp_q[1];
  assign m0_hrdata = (st[0] == ACC && !pwrite[0]) ? ram_rdata : rdata_q[0];
  assign m1_hrdata = (st[1] == ACC && !pwrite[1]) ? ram_rdata : rdata_q[1];

endmodule
